// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction-fetch slice.
//   INST_BUS    instruction bus width
//   ADDR_BUS    instruction-address / PC width
//   INST_NOP    bubble encoding placed in IF/ID when no real instruction is present
//   RESET_ADDR  first fetch address after reset
package inst_fetch_pkg;

    localparam int          INST_BUS   = 16;
    localparam int          ADDR_BUS   = 16;
    localparam logic [15:0] INST_NOP   = 16'h0800;
    localparam logic [15:0] RESET_ADDR = 16'h0000;

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   hold            keep current contents (decode stall); wins over load
//   load            capture d_inst/d_pc as a real instruction
//                   (hold=0, load=0 inserts a bubble: valid=0, inst=NOP)
//   d_inst, d_pc    instruction and its address
//   valid           register holds a real instruction
//   inst, pc, npc   registered instruction, its address and address+1
// On a bubble pc/npc keep their last value; decode ignores them when valid=0.
module if_id_reg
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_BUS,
    parameter int                INST_W   = INST_BUS,
    parameter logic [INST_W-1:0] NOP_INST = INST_NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              load,
    input  logic [INST_W-1:0] d_inst,
    input  logic [ADDR_W-1:0] d_pc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= '0;
            npc   <= '0;
        end else if (hold) begin
            valid <= valid;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= d_inst;
            pc    <= d_pc;
            npc   <= d_pc + PC_ONE;
        end else begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage with IF/ID register.
// Drives the PC over a req/ack instruction-memory port and presents
// {inst, pc, pc+1} to decode. Handles decode stalls (skid register) and
// branch redirects from ID, including redirects during an outstanding fetch.
//
// Optional feature macro: IF_DELAY_SLOT_EN
//   defined   - the instruction after a branch is a delay slot and is delivered
//   undefined - that instruction is squashed and replaced by a bubble
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   stall_i               decode stall, IF/ID holds
//   redirect_i            taken branch/jump in ID (ignored while stall_i=1)
//   redirect_pc_i         redirect target
//   imem_req_o/addr_o     fetch request and address
//   imem_rdata_i/ack_i    returned instruction, qualified by ack
//   id_valid_o            IF/ID holds a real instruction
//   id_inst_o/pc_o/npc_o  instruction, its address, address+1
//   dbg_state             current FSM state (0 = S_FETCH, 1 = S_HOLD)
//
// Memory handshake: imem_req_o is high in S_FETCH; the request is complete on
// the first rising edge where imem_ack_i=1 (may be the same cycle as the
// request). imem_addr_o is stable from request until ack and a request is never
// withdrawn except by reset.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_BUS,
    parameter int                INST_W   = INST_BUS,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_ADDR,
    parameter logic [INST_W-1:0] NOP_INST = INST_NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [INST_W-1:0] imem_rdata_i,
    input  logic              imem_ack_i,
    output logic              id_valid_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [ADDR_W-1:0] id_npc_o,
    output logic              dbg_state
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
    logic              pend_q, pend_d;
    logic              discard_q, discard_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    // out_q: a request was open at the last edge without an ack.
    // flush_q: that request was abandoned by reset; its late ack must be dropped.
    logic              out_q, flush_q, flush_d;

    logic              in_fetch, redir_go, ack_take, squash, keep;
    logic              ifid_hold, ifid_load;
    logic [INST_W-1:0] ifid_inst;
    logic [ADDR_W-1:0] ifid_pc;

    assign in_fetch = (state_q == S_FETCH);
    assign redir_go = redirect_i & ~stall_i;
    // An ack belongs to the current fetch unless it is the late reply to a
    // request abandoned by reset.
    assign ack_take = in_fetch & imem_ack_i & ~flush_q;
`ifdef IF_DELAY_SLOT_EN
    assign squash = 1'b0;
`else
    // Data fetched right after a branch: either returned with the redirect or
    // arriving later for a fetch that was open when the redirect came.
    assign squash = ack_take & (discard_q | redir_go);
`endif
    assign keep = ack_take & ~squash;

    assign imem_req_o  = rst & in_fetch;
    assign imem_addr_o = pc_q;
    assign dbg_state   = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (keep && stall_i) state_d = S_HOLD;
            S_HOLD:  if (!stall_i)        state_d = S_FETCH;
            default:                      state_d = S_FETCH;
        endcase
    end

    // Output / datapath control
    always_comb begin
        ifid_hold   = stall_i;
        ifid_load   = 1'b0;
        ifid_inst   = imem_rdata_i;
        ifid_pc     = pc_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        discard_d   = discard_q;
        redir_pc_d  = redir_pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        flush_d     = flush_q;

        // Newest redirect target always wins.
        if (redir_go) redir_pc_d = redirect_pc_i;

        if (in_fetch) begin
            if (imem_ack_i && flush_q) flush_d = 1'b0;
            if (ack_take) begin
                pend_d    = 1'b0;
                discard_d = 1'b0;
                if (redir_go)    pc_d = redirect_pc_i;
                else if (pend_q) pc_d = redir_pc_q;
                else             pc_d = pc_q + PC_ONE;
                if (keep) begin
                    if (stall_i) begin
                        skid_inst_d = imem_rdata_i;
                        skid_pc_d   = pc_q;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end
            end else if (redir_go) begin
                // Fetch still open: keep its address on the bus, jump on its ack.
                pend_d = 1'b1;
`ifdef IF_DELAY_SLOT_EN
                discard_d = 1'b0;
`else
                discard_d = 1'b1;
`endif
            end
        end else begin
            ifid_inst = skid_inst_q;
            ifid_pc   = skid_pc_q;
            if (!stall_i) begin
                if (redir_go) pc_d = redirect_pc_i;
`ifdef IF_DELAY_SLOT_EN
                ifid_load = 1'b1;
`else
                if (redir_go) skid_inst_d = NOP_INST;
                else          ifid_load   = 1'b1;
`endif
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            redir_pc_q  <= RESET_PC;
            pend_q      <= 1'b0;
            discard_q   <= 1'b0;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= '0;
            // Remember an abandoned request across reset until its ack shows up.
            out_q       <= out_q & ~imem_ack_i;
            flush_q     <= out_q & ~imem_ack_i;
        end else begin
            pc_q        <= pc_d;
            redir_pc_q  <= redir_pc_d;
            pend_q      <= pend_d;
            discard_q   <= discard_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            out_q       <= imem_req_o & ~imem_ack_i;
            flush_q     <= flush_d;
        end
    end

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .hold   (ifid_hold),
        .load   (ifid_load),
        .d_inst (ifid_inst),
        .d_pc   (ifid_pc),
        .valid  (id_valid_o),
        .inst   (id_inst_o),
        .pc     (id_pc_o),
        .npc    (id_npc_o)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch. Inputs change 1 time unit after a rising
// edge; outputs are checked at the same point, so registered outputs reflect
// the edge just taken and imem_req_o/imem_addr_o describe the current cycle.
// Instructions expected in IF/ID are queued in exp_q and consumed in order.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = 16'h0;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic [15:0] imem_rdata_i = 16'h0;
  logic        imem_ack_i = 1'b0;
  logic        id_valid_o;
  logic [15:0] id_inst_o;
  logic [15:0] id_pc_o;
  logic [15:0] id_npc_o;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .imem_ack_i    (imem_ack_i),
    .id_valid_o    (id_valid_o),
    .id_inst_o     (id_inst_o),
    .id_pc_o       (id_pc_o),
    .id_npc_o      (id_npc_o),
    .dbg_state     (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [15:0] data, input logic stall,
                       input logic redir, input logic [15:0] tgt);
    imem_ack_i    = ack;
    imem_rdata_i  = data;
    stall_i       = stall;
    redirect_i    = redir;
    redirect_pc_i = tgt;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_fetch(input string tag, input logic [15:0] addr);
    chk({tag, " req"}, 32'(imem_req_o), 32'd1);
    chk({tag, " addr"}, 32'(imem_addr_o), 32'(addr));
  endtask

  task automatic expect_bubble(input string tag);
    chk({tag, " bubble valid"}, 32'(id_valid_o), 32'd0);
    chk({tag, " bubble inst"}, 32'(id_inst_o), 32'h0800);
  endtask

  task automatic expect_id(input string tag, input logic [15:0] pc);
    logic [15:0] e;
    logic [15:0] npc_e;
    npc_e = pc + 16'd1;
    chk({tag, " sb nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk({tag, " valid"}, 32'(id_valid_o), 32'd1);
    chk({tag, " inst"}, 32'(id_inst_o), 32'(e));
    chk({tag, " pc"}, 32'(id_pc_o), 32'(pc));
    chk({tag, " npc"}, 32'(id_npc_o), 32'(npc_e));
  endtask

  task automatic expect_frozen(input string tag, input logic [15:0] inst, input logic [15:0] pc);
    chk({tag, " frozen valid"}, 32'(id_valid_o), 32'd1);
    chk({tag, " frozen inst"}, 32'(id_inst_o), 32'(inst));
    chk({tag, " frozen pc"}, 32'(id_pc_o), 32'(pc));
  endtask

  initial begin
    // reset state
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick(); tick(); tick();
    chk("rst valid", 32'(id_valid_o), 32'd0);
    chk("rst inst", 32'(id_inst_o), 32'h0800);
    chk("rst pc", 32'(id_pc_o), 32'h0);
    chk("rst npc", 32'(id_npc_o), 32'h0);
    chk("rst req", 32'(imem_req_o), 32'd0);
    chk("rst state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    #1;
    expect_fetch("rst release", 16'h0000);

    // 1: ack every cycle
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h4801 + 16'(i) * 16'h0101);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h4801 + 16'(i) * 16'h0101, 1'b0, 1'b0, 16'h0);
      tick();
      expect_id("t1", 16'(i));
      expect_fetch("t1 next", 16'(i + 1));
    end

    // 2: ack delayed three cycles on addr 5
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      expect_fetch("t2 wait", 16'h0005);
      tick();
      expect_bubble("t2");
    end
    exp_q.push_back(16'hA505);
    drive(1'b1, 16'hA505, 1'b0, 1'b0, 16'h0);
    tick();
    expect_id("t2", 16'h0005);
    expect_fetch("t2 next", 16'h0006);

    // 3: two-cycle stall with ack in the first
    exp_q.push_back(16'hB606);
    exp_q.push_back(16'hC707);
    drive(1'b1, 16'hB606, 1'b1, 1'b0, 16'h0);
    tick();
    expect_frozen("t3 c1", 16'hA505, 16'h0005);
    chk("t3 c1 req", 32'(imem_req_o), 32'd0);
    chk("t3 c1 state", 32'(dbg_state), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    expect_frozen("t3 c2", 16'hA505, 16'h0005);
    chk("t3 c2 req", 32'(imem_req_o), 32'd0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    expect_id("t3 skid", 16'h0006);
    expect_fetch("t3 resume", 16'h0007);
    drive(1'b1, 16'hC707, 1'b0, 1'b0, 16'h0);
    tick();
    expect_id("t3", 16'h0007);
    expect_fetch("t3 next", 16'h0008);

    // 4: redirect with ack in the same cycle (first to 0x10, then branch at 0x10 to 0x40)
`ifdef IF_DELAY_SLOT_EN
    exp_q.push_back(16'h8808);
`endif
    drive(1'b1, 16'h8808, 1'b0, 1'b1, 16'h0010);
    tick();
`ifdef IF_DELAY_SLOT_EN
    expect_id("t4a slot", 16'h0008);
`else
    expect_bubble("t4a squash");
`endif
    expect_fetch("t4a target", 16'h0010);
    exp_q.push_back(16'hD010);
    drive(1'b1, 16'hD010, 1'b0, 1'b0, 16'h0);
    tick();
    expect_id("t4 branch", 16'h0010);
    expect_fetch("t4 seq", 16'h0011);
`ifdef IF_DELAY_SLOT_EN
    exp_q.push_back(16'hD011);
`endif
    drive(1'b1, 16'hD011, 1'b0, 1'b1, 16'h0040);
    tick();
`ifdef IF_DELAY_SLOT_EN
    expect_id("t4 slot", 16'h0011);
`else
    expect_bubble("t4 squash");
`endif
    expect_fetch("t4 target", 16'h0040);
    exp_q.push_back(16'hD040);
    drive(1'b1, 16'hD040, 1'b0, 1'b0, 16'h0);
    tick();
    expect_id("t4", 16'h0040);
    expect_fetch("t4 next", 16'h0041);

    // 5: redirect to 0x80 while fetch of 0x21 is outstanding
`ifdef IF_DELAY_SLOT_EN
    exp_q.push_back(16'hE041);
`endif
    drive(1'b1, 16'hE041, 1'b0, 1'b1, 16'h0020);
    tick();
`ifdef IF_DELAY_SLOT_EN
    expect_id("t5a slot", 16'h0041);
`else
    expect_bubble("t5a squash");
`endif
    exp_q.push_back(16'hE020);
    drive(1'b1, 16'hE020, 1'b0, 1'b0, 16'h0);
    tick();
    expect_id("t5 branch", 16'h0020);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0080);
    expect_fetch("t5 redir", 16'h0021);
    tick();
    expect_bubble("t5 w1");
    expect_fetch("t5 w1", 16'h0021);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    expect_bubble("t5 w2");
    expect_fetch("t5 w2", 16'h0021);
`ifdef IF_DELAY_SLOT_EN
    exp_q.push_back(16'hE021);
`endif
    drive(1'b1, 16'hE021, 1'b0, 1'b0, 16'h0);
    tick();
`ifdef IF_DELAY_SLOT_EN
    expect_id("t5 slot", 16'h0021);
`else
    expect_bubble("t5 discard");
`endif
    expect_fetch("t5 target", 16'h0080);
    exp_q.push_back(16'hE080);
    drive(1'b1, 16'hE080, 1'b0, 1'b0, 16'h0);
    tick();
    expect_id("t5", 16'h0080);
    expect_fetch("t5 next", 16'h0081);

    // 6: reset during an outstanding fetch, then a late ack
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    expect_bubble("t6 wait");
    rst = 1'b0;
    #1;
    chk("t6 rst req", 32'(imem_req_o), 32'd0);
    tick();
    chk("t6 rst valid", 32'(id_valid_o), 32'd0);
    chk("t6 rst inst", 32'(id_inst_o), 32'h0800);
    chk("t6 rst pc", 32'(id_pc_o), 32'h0);
    chk("t6 rst state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    #1;
    expect_fetch("t6 restart", 16'h0000);
    drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0);
    tick();
    expect_bubble("t6 late ack");
    expect_fetch("t6 refetch", 16'h0000);
    exp_q.push_back(16'h1000);
    drive(1'b1, 16'h1000, 1'b0, 1'b0, 16'h0);
    tick();
    expect_id("t6", 16'h0000);
    expect_fetch("t6 next", 16'h0001);

    // PC wrap 0xFFFF -> 0x0000
`ifdef IF_DELAY_SLOT_EN
    exp_q.push_back(16'h1001);
`endif
    drive(1'b1, 16'h1001, 1'b0, 1'b1, 16'hFFFF);
    tick();
`ifdef IF_DELAY_SLOT_EN
    expect_id("wrap slot", 16'h0001);
`else
    expect_bubble("wrap squash");
`endif
    expect_fetch("wrap top", 16'hFFFF);
    exp_q.push_back(16'h1FFF);
    drive(1'b1, 16'h1FFF, 1'b0, 1'b0, 16'h0);
    tick();
    expect_id("wrap", 16'hFFFF);
    expect_fetch("wrap next", 16'h0000);
    exp_q.push_back(16'h2000);
    drive(1'b1, 16'h2000, 1'b0, 1'b0, 16'h0);
    tick();
    expect_id("wrap0", 16'h0000);
    expect_fetch("wrap0 next", 16'h0001);

    // redirect while stalled is ignored
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h1234);
    tick();
    expect_frozen("stall redir", 16'h2000, 16'h0000);
    expect_fetch("stall redir", 16'h0001);
    exp_q.push_back(16'h3001);
    drive(1'b1, 16'h3001, 1'b0, 1'b0, 16'h0);
    tick();
    expect_id("stall redir", 16'h0001);
    expect_fetch("stall redir next", 16'h0002);

    // final report
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("sb drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
